// File: rtl/fetch_sequencer_if.sv
// Handshake/bus bundle between the fetch sequencer and its control unit.
// The master drives launch, control and LUT-write signals; the slave returns fetch status.
interface fetch_sequencer_if #(
  parameter int unsigned PC_W = 10
);
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            br_ctrl;
  logic            jmp_ctrl;
  logic            done_ctrl;
  logic            br_cond;
  logic [3:0]      tgt_sel;
  logic            lut_we;
  logic [3:0]      lut_waddr;
  logic [PC_W-1:0] lut_wdata;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            halt;
  logic [15:0]     cycle_cnt;

  modport master (
    output start, start_addr, br_ctrl, jmp_ctrl, done_ctrl, br_cond, tgt_sel,
    output lut_we, lut_waddr, lut_wdata,
    input  pc, pc_valid, halt, cycle_cnt
  );

  modport slave (
    input  start, start_addr, br_ctrl, jmp_ctrl, done_ctrl, br_cond, tgt_sel,
    input  lut_we, lut_waddr, lut_wdata,
    output pc, pc_valid, halt, cycle_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT FSM with sequential fetch, LUT-based
// jump/branch targets, and a saturating count of RUN cycles since launch.
module fetch_sequencer #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            pc_valid_q, halt_q;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] tgt;

  // Read from registered contents so a same-cycle write never bypasses.
  assign tgt = lut_q[bus.tgt_sel];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          state_d = StRun;
          pc_d    = bus.start_addr;
          cnt_d   = 16'd0;
        end
      end
      StRun: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (bus.done_ctrl) begin
          state_d = StHalt;
        end else if (bus.jmp_ctrl) begin
          pc_d = tgt;
        end else if (bus.br_ctrl && bus.br_cond) begin
          pc_d = tgt;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      cnt_q      <= '0;
      pc_valid_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      pc_valid_q <= (state_d == StRun);
      halt_q     <= (state_d == StHalt);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (bus.lut_we) begin
      lut_q[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.halt      = halt_q;
  assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: launch, jump/branch, priority,
// LUT collision, wrap, saturation and asynchronous reset.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fetch_sequencer_if #(.PC_W(10)) bus ();

  fetch_sequencer #(
    .PC_W      (10),
    .LUT_DEPTH (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [9:0] pc, input logic vld,
                            input logic hlt, input logic [15:0] cnt);
    chk({tag, ".pc"}, 32'(bus.pc), 32'(pc));
    chk({tag, ".pc_valid"}, 32'(bus.pc_valid), 32'(vld));
    chk({tag, ".halt"}, 32'(bus.halt), 32'(hlt));
    chk({tag, ".cycle_cnt"}, 32'(bus.cycle_cnt), 32'(cnt));
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.br_ctrl    = 1'b0;
    bus.jmp_ctrl   = 1'b0;
    bus.done_ctrl  = 1'b0;
    bus.br_cond    = 1'b0;
    bus.tgt_sel    = '0;
    bus.lut_we     = 1'b0;
    bus.lut_waddr  = '0;
    bus.lut_wdata  = '0;

    #12;
    chk_status("reset", 10'h000, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;

    // Program LUT while idle; stray controls must not move the pc.
    bus.jmp_ctrl  = 1'b1;
    bus.lut_we    = 1'b1;
    bus.lut_waddr = 4'd5;
    bus.lut_wdata = 10'h200;
    step();
    bus.lut_waddr = 4'd2;
    bus.lut_wdata = 10'h100;
    step();
    bus.lut_waddr = 4'd3;
    bus.lut_wdata = 10'h040;
    step();
    bus.lut_we   = 1'b0;
    bus.jmp_ctrl = 1'b0;
    chk_status("idle", 10'h000, 1'b0, 1'b0, 16'd0);

    // Launch and sequential fetch.
    bus.start_addr = 10'h010;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    chk_status("launch", 10'h010, 1'b1, 1'b0, 16'd0);
    step();
    chk("seq1.pc", 32'(bus.pc), 32'h011);
    step();
    chk("seq2.pc", 32'(bus.pc), 32'h012);
    step();
    chk_status("seq3", 10'h013, 1'b1, 1'b0, 16'd3);

    // Jump, branch not taken, branch taken.
    bus.jmp_ctrl = 1'b1;
    bus.tgt_sel  = 4'd5;
    step();
    bus.jmp_ctrl = 1'b0;
    chk("jmp.pc", 32'(bus.pc), 32'h200);
    bus.br_ctrl = 1'b1;
    bus.br_cond = 1'b0;
    step();
    chk("br_nt.pc", 32'(bus.pc), 32'h201);
    bus.br_cond = 1'b1;
    step();
    chk("br_t.pc", 32'(bus.pc), 32'h200);
    bus.br_ctrl = 1'b0;
    bus.br_cond = 1'b0;

    // Same-cycle write to the selected entry uses the old target.
    bus.jmp_ctrl  = 1'b1;
    bus.tgt_sel   = 4'd2;
    bus.lut_we    = 1'b1;
    bus.lut_waddr = 4'd2;
    bus.lut_wdata = 10'h155;
    step();
    bus.lut_we = 1'b0;
    chk("coll_old.pc", 32'(bus.pc), 32'h100);
    step();
    chk("coll_new.pc", 32'(bus.pc), 32'h155);

    // done beats jmp; HALT holds and ignores controls.
    bus.tgt_sel = 4'd3;
    step();
    chk("to40.pc", 32'(bus.pc), 32'h040);
    bus.done_ctrl = 1'b1;
    bus.tgt_sel   = 4'd5;
    step();
    bus.done_ctrl = 1'b0;
    chk_status("halt", 10'h040, 1'b0, 1'b1, 16'd10);
    step();
    bus.jmp_ctrl = 1'b0;
    chk_status("halt_hold", 10'h040, 1'b0, 1'b1, 16'd10);
    bus.start_addr = 10'h000;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    chk_status("relaunch", 10'h000, 1'b1, 1'b0, 16'd0);

    // pc wrap via a LUT entry written while running.
    bus.lut_we    = 1'b1;
    bus.lut_waddr = 4'd7;
    bus.lut_wdata = 10'h3FF;
    step();
    bus.lut_we = 1'b0;
    chk("pre_wrap.pc", 32'(bus.pc), 32'h001);
    bus.jmp_ctrl = 1'b1;
    bus.tgt_sel  = 4'd7;
    step();
    bus.jmp_ctrl = 1'b0;
    chk("at3ff.pc", 32'(bus.pc), 32'h3FF);
    step();
    chk_status("wrap", 10'h000, 1'b1, 1'b0, 16'd3);

    // Saturation of cycle_cnt.
    repeat (65540) @(posedge clk);
    #1;
    chk("sat.cycle_cnt", 32'(bus.cycle_cnt), 32'hFFFF);
    step();
    chk("sat_hold.cycle_cnt", 32'(bus.cycle_cnt), 32'hFFFF);
    chk("sat.pc_valid", 32'(bus.pc_valid), 32'd1);

    // Async reset between edges.
    #3;
    reset = 1'b1;
    #1;
    chk_status("async_rst", 10'h000, 1'b0, 1'b0, 16'd0);
    #1;
    reset = 1'b0;
    step();
    step();
    chk_status("post_rst_idle", 10'h000, 1'b0, 1'b0, 16'd0);

    // Launch on the first edge after reset release; LUT must be cleared.
    reset = 1'b1;
    #2;
    bus.start      = 1'b1;
    bus.start_addr = 10'h055;
    reset          = 1'b0;
    step();
    bus.start = 1'b0;
    chk_status("first_edge", 10'h055, 1'b1, 1'b0, 16'd0);
    bus.jmp_ctrl = 1'b1;
    bus.tgt_sel  = 4'd5;
    step();
    bus.jmp_ctrl = 1'b0;
    chk("lut_cleared.pc", 32'(bus.pc), 32'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 10: program-counter width in bits.
REQ-002 Parameter LUT_DEPTH, default 16: number of branch/jump target entries, indexed by 4-bit tgt_sel.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; requests program launch from IDLE or HALT.
REQ-006 start_addr  input  PC_W  first instruction address, sampled when a launch is accepted.
REQ-007 br_ctrl  input  1  branch-instruction indication from the control unit.
REQ-008 jmp_ctrl  input  1  unconditional-jump indication from the control unit.
REQ-009 done_ctrl  input  1  DONE-instruction indication from the control unit.
REQ-010 br_cond  input  1  accumulator bit 0; branch is taken when 1.
REQ-011 tgt_sel  input  4  instruction bits [3:0]; selects the target LUT entry.
REQ-012 lut_we  input  1  target-LUT write enable.
REQ-013 lut_waddr  input  4  target-LUT write index.
REQ-014 lut_wdata  input  PC_W  target-LUT write data.
REQ-015 pc  output  PC_W  current instruction fetch address.
REQ-016 pc_valid  output  1  high only in RUN; the fetched instruction is executing.
REQ-017 halt  output  1  high only in HALT.
REQ-018 cycle_cnt  output  16  count of RUN cycles since the last launch.

Function
REQ-019 FSM states: IDLE, RUN, HALT; pc_valid = (state==RUN); halt = (state==HALT).
REQ-020 IDLE: start=1 -> RUN next cycle; pc <= start_addr; cycle_cnt <= 0.
REQ-021 HALT: start=1 -> RUN, same loads as REQ-020; start=0 -> remain in HALT with pc held.
REQ-022 RUN: start ignored; control inputs evaluated each cycle with priority done_ctrl > jmp_ctrl > br_ctrl.
REQ-023 RUN with done_ctrl=1 -> HALT next cycle; pc held at the DONE address.
REQ-024 RUN with jmp_ctrl=1 -> pc <= lut[tgt_sel].
REQ-025 RUN with br_ctrl=1 and br_cond=1 -> pc <= lut[tgt_sel]; with br_cond=0 -> pc <= pc+1.
REQ-026 RUN with no control asserted -> pc <= pc+1, modulo 2^PC_W (all-ones wraps to 0).
REQ-027 Control inputs are ignored outside RUN.
REQ-028 cycle_cnt increments by 1 on every RUN cycle, including the DONE cycle; it saturates at 16'hFFFF and holds in IDLE and HALT.
REQ-029 LUT write: on lut_we=1, lut[lut_waddr] <= lut_wdata; writes are accepted in any state.
REQ-030 LUT read is combinational from registered contents; a same-cycle write to the selected entry does not affect the target (old value used).
REQ-031 Target and next-pc latency: 1 cycle; pc updates on the edge following the decision cycle.

Reset
REQ-032 Assertion of reset immediately, without waiting for a clock edge, forces: state=IDLE, pc=0, pc_valid=0, halt=0, cycle_cnt=0, and all LUT entries=0.
REQ-033 Reset asserted mid-RUN aborts execution; after release the block waits in IDLE for start.
REQ-034 If start=1 on the first edge after reset release, launch proceeds per REQ-020.

Verification
REQ-035 Launch/sequential: start_addr=0x010, start pulse, no controls for 3 cycles -> pc 0x010,0x011,0x012,0x013; pc_valid=1; cycle_cnt=3.
REQ-036 Jump/branch: lut[5]=0x200; jmp_ctrl with tgt_sel=5 -> pc=0x200; branch with br_cond=0 -> pc+1; branch with br_cond=1 -> 0x200.
REQ-037 Priority/halt: done_ctrl=1 together with jmp_ctrl=1 at pc=0x040 -> HALT, pc stays 0x040, halt=1, pc_valid=0; a later start with start_addr=0 -> RUN at pc=0, cycle_cnt=0.
REQ-038 Wrap/saturation: pc=0x3FF with no controls -> next pc=0x000; more than 65535 RUN cycles -> cycle_cnt holds at 0xFFFF.
REQ-039 LUT collision: lut[2]=0x100, then a write lut[2]<=0x155 in the same cycle as a jump with tgt_sel=2 -> pc=0x100; the next jump with tgt_sel=2 -> pc=0x155.
REQ-040 Async reset: assert reset between clock edges during RUN -> outputs at reset values before the next edge; after release, start=0 keeps the block in IDLE.
